// File: rtl/cache_pkg.sv
// Shared widths, MSI encoding and request/response bundles for the
// set-associative cache model (default configuration: 2 ways, 1024 sets).
package cache_pkg;

    localparam int CACHE_NUM_WAYS = 2;
    localparam int CACHE_INDEX_W  = 10;
    localparam int CACHE_TAG_W    = 20;
    localparam int CACHE_DATA_W   = 32;
    localparam int CACHE_MSI_W    = 2;

    localparam int BE_W   = CACHE_DATA_W / 8;
    localparam int WAY_W  = (CACHE_NUM_WAYS > 1) ? $clog2(CACHE_NUM_WAYS) : 1;
    localparam int REQ_W  = BE_W + CACHE_TAG_W + CACHE_INDEX_W
                          + CACHE_DATA_W + 1 + CACHE_MSI_W + 1;
    localparam int RESP_W = 1 + WAY_W + CACHE_TAG_W + CACHE_DATA_W
                          + CACHE_MSI_W;

    typedef enum logic [1:0] {
        MSI_I = 2'd0,
        MSI_S = 2'd1,
        MSI_M = 2'd2
    } msi_e;

    typedef struct packed {
        logic [BE_W-1:0]          byte_en;
        logic [CACHE_TAG_W-1:0]   tag;
        logic [CACHE_INDEX_W-1:0] index;
        logic [CACHE_DATA_W-1:0]  data;
        logic                     msi_valid;
        logic [CACHE_MSI_W-1:0]   msi_data;
        logic                     ignore_response;
    } cache_req_t;

    typedef struct packed {
        logic                    hit;
        logic [WAY_W-1:0]        way;
        logic [CACHE_TAG_W-1:0]  tag;
        logic [CACHE_DATA_W-1:0] data;
        logic [CACHE_MSI_W-1:0]  msi;
    } cache_resp_t;

    // Way-select width; a direct-mapped cache still carries a 1-bit field.
    function automatic int way_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Per-set round-robin victim pointers.
// Ports: CLK, RST (sync, active-high clear), index (set), adv (advance), ptr.
module cache_victim_sel
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 2,
    parameter int INDEX_W  = 10,
    parameter int WAY_BITS = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [INDEX_W-1:0]  index,
    input  logic                adv,
    output logic [WAY_BITS-1:0] ptr
);

    localparam int SETS = 1 << INDEX_W;
    localparam logic [WAY_BITS-1:0] LAST = WAY_BITS'(NUM_WAYS - 1);

    logic [WAY_BITS-1:0] ptr_q [SETS];

    assign ptr = ptr_q[index];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else if (adv) begin
            ptr_q[index] <= (ptr_q[index] == LAST) ? '0 : ptr_q[index] + 1'b1;
        end
    end

endmodule

// File: rtl/cache_assoc_model.sv
// N-way set-associative behavioural cache with put/get handshakes.
// Ports: CLK, RST (sync, active-high), put_valid/put_ready/put_request,
// get_valid/get_ready/get_response, and stat_hits/stat_misses when the
// CACHE_STATS_EN macro is defined.
module cache_assoc_model
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = CACHE_NUM_WAYS,
    parameter int INDEX_W  = CACHE_INDEX_W,
    parameter int TAG_W    = CACHE_TAG_W,
    parameter int DATA_W   = CACHE_DATA_W,
    parameter int MSI_W    = CACHE_MSI_W,
    localparam int WAY_BITS  = way_bits(NUM_WAYS),
    localparam int BE_BITS   = DATA_W / 8,
    localparam int REQ_BITS  = BE_BITS + TAG_W + INDEX_W + DATA_W + 2 + MSI_W,
    localparam int RESP_BITS = 1 + WAY_BITS + TAG_W + DATA_W + MSI_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 put_valid,
    output logic                 put_ready,
    input  logic [REQ_BITS-1:0]  put_request,
    input  logic                 get_valid,
    output logic                 get_ready,
    output logic [RESP_BITS-1:0] get_response
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]          stat_hits,
    output logic [31:0]          stat_misses
`endif
);

    localparam int SETS = 1 << INDEX_W;

    typedef struct packed {
        logic [BE_BITS-1:0] byte_en;
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
        logic [DATA_W-1:0]  data;
        logic               msi_valid;
        logic [MSI_W-1:0]   msi_data;
        logic               ignore_response;
    } req_t;

    typedef struct packed {
        logic                hit;
        logic [WAY_BITS-1:0] way;
        logic [TAG_W-1:0]    tag;
        logic [DATA_W-1:0]   data;
        logic [MSI_W-1:0]    msi;
    } resp_t;

    logic [TAG_W-1:0]  tag_mem  [NUM_WAYS][SETS];
    logic [DATA_W-1:0] data_mem [NUM_WAYS][SETS];
    logic [MSI_W-1:0]  msi_mem  [NUM_WAYS][SETS];
    logic [SETS-1:0]   valid_q  [NUM_WAYS];

    req_t                last;
    logic                has_request;
    logic                put_fire;
    logic                get_fire;
    logic                retire;
    logic                wr_en;
    logic                inval;
    logic                hit;
    logic [WAY_BITS-1:0] hit_way;
    logic [WAY_BITS-1:0] victim;
    logic [WAY_BITS-1:0] sel_way;
    logic [TAG_W-1:0]    rtag;
    logic [DATA_W-1:0]   rdata;
    logic [MSI_W-1:0]    rmsi;
    logic [DATA_W-1:0]   mask;
    logic [DATA_W-1:0]   merged;
    resp_t               resp;

    assign put_ready = !RST && (!has_request || get_fire || last.ignore_response);
    assign get_ready = has_request && !last.ignore_response;
    assign put_fire  = put_valid && put_ready;
    assign get_fire  = get_valid && get_ready;
    assign retire    = has_request && (get_fire || last.ignore_response);

    // A request dropped by reset must leave the arrays untouched.
    assign wr_en = retire && !RST && (|last.byte_en || last.msi_valid);
    assign inval = hit && last.msi_valid
                && (last.msi_data == MSI_W'(MSI_I));

    // Descending scan so the lowest matching way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][last.index] && tag_mem[w][last.index] == last.tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    assign sel_way = hit ? hit_way : victim;

    always_comb begin
        rtag  = '0;
        rdata = '0;
        rmsi  = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (WAY_BITS'(w) == sel_way) begin
                rtag  = tag_mem[w][last.index];
                rdata = data_mem[w][last.index];
                rmsi  = msi_mem[w][last.index];
            end
        end
    end

    always_comb begin
        mask = '0;
        for (int b = 0; b < BE_BITS; b++) begin
            mask[b*8 +: 8] = {8{last.byte_en[b]}};
        end
    end

    assign merged = (rdata & ~mask) | (last.data & mask);

    assign resp.hit  = hit;
    assign resp.way  = sel_way;
    assign resp.tag  = rtag;
    assign resp.data = rdata;
    assign resp.msi  = rmsi;
    assign get_response = resp;

    always_ff @(posedge CLK) begin
        if (RST) begin
            has_request <= 1'b0;
        end else begin
            has_request <= put_fire
                        || (has_request && !get_fire && !last.ignore_response);
        end
    end

    always_ff @(posedge CLK) begin
        if (put_fire) begin
            last <= put_request;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_BITS'(w) == sel_way) begin
                    tag_mem[w][last.index]  <= last.tag;
                    data_mem[w][last.index] <= merged;
                    msi_mem[w][last.index]  <= last.msi_valid ? last.msi_data : rmsi;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                valid_q[w] <= '0;
            end
        end else if (wr_en) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_BITS'(w) == sel_way) begin
                    valid_q[w][last.index] <= !inval;
                end
            end
        end
    end

    cache_victim_sel #(
        .NUM_WAYS (NUM_WAYS),
        .INDEX_W  (INDEX_W),
        .WAY_BITS (WAY_BITS)
    ) u_victim (
        .CLK   (CLK),
        .RST   (RST),
        .index (last.index),
        .adv   (wr_en && !hit),
        .ptr   (victim)
    );

`ifdef CACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (retire) begin
            if (hit) begin
                stat_hits <= stat_hits + 32'd1;
            end else begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_assoc_model.sv
// Directed self-checking bench for cache_assoc_model (default parameters).
// Covers reset, hit/miss, partial writes, eviction, ignore_response, reset drop.
module tb_cache_assoc_model;
    import cache_pkg::*;

    logic              CLK;
    logic              RST;
    logic              put_valid;
    logic              put_ready;
    logic [REQ_W-1:0]  put_request;
    logic              get_valid;
    logic              get_ready;
    logic [RESP_W-1:0] get_response;
`ifdef CACHE_STATS_EN
    logic [31:0]       stat_hits;
    logic [31:0]       stat_misses;
`endif

    int checks = 0;
    int errors = 0;

    cache_assoc_model dut (
        .CLK          (CLK),
        .RST          (RST),
        .put_valid    (put_valid),
        .put_ready    (put_ready),
        .put_request  (put_request),
        .get_valid    (get_valid),
        .get_ready    (get_ready),
        .get_response (get_response)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits    (stat_hits),
        .stat_misses  (stat_misses)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [3:0] be, input logic [19:0] tag,
                       input logic [9:0] idx, input logic [31:0] data,
                       input logic mv, input logic [1:0] md,
                       input logic ign);
        int n = 0;
        @(negedge CLK);
        put_request = {be, tag, idx, data, mv, md, ign};
        put_valid = 1'b1;
        while (!put_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("put_ready", put_ready, 1'b1);
        @(posedge CLK);
        #1 put_valid = 1'b0;
    endtask

    task automatic get(input string name, input logic hit,
                       input logic way, input logic full,
                       input logic [19:0] tag, input logic [31:0] data,
                       input logic [1:0] msi);
        cache_resp_t r;
        @(negedge CLK);
        r = get_response;
        chk({name, ".get_ready"}, get_ready, 1'b1);
        chk({name, ".hit"}, r.hit, hit);
        chk({name, ".way"}, r.way, way);
        if (full) begin
            chk({name, ".tag"}, r.tag, tag);
            chk({name, ".data"}, r.data, data);
            chk({name, ".msi"}, r.msi, msi);
        end
        get_valid = 1'b1;
        @(posedge CLK);
        #1 get_valid = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        put_valid = 1'b0;
        get_valid = 1'b0;
        put_request = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst.put_ready", put_ready, 1'b0);
        chk("rst.get_ready", get_ready, 1'b0);
`ifdef CACHE_STATS_EN
        chk("rst.hits", stat_hits, 32'd0);
        chk("rst.misses", stat_misses, 32'd0);
`endif
        RST = 1'b0;
        #1 chk("post_rst.put_ready", put_ready, 1'b1);

        // 1: read-only miss, no write, victim stays 0
        put(4'h0, 20'h12, 10'd5, 32'h0, 1'b0, 2'd0, 1'b0);
        get("t1", 1'b0, 1'b0, 1'b0, '0, '0, '0);

        // 2: full write then read back
        put(4'hF, 20'h12, 10'd5, 32'hDEADBEEF, 1'b1, 2'd2, 1'b0);
        get("t2w", 1'b0, 1'b0, 1'b0, '0, '0, '0);
        put(4'h0, 20'h12, 10'd5, 32'h0, 1'b0, 2'd0, 1'b0);
        get("t2r", 1'b1, 1'b0, 1'b1, 20'h12, 32'hDEADBEEF, 2'd2);

        // 3: partial byte write; response shows row before update
        put(4'b0010, 20'h12, 10'd5, 32'h0000AB00, 1'b0, 2'd0, 1'b0);
        get("t3w", 1'b1, 1'b0, 1'b1, 20'h12, 32'hDEADBEEF, 2'd2);
        put(4'h0, 20'h12, 10'd5, 32'h0, 1'b0, 2'd0, 1'b0);
        get("t3r", 1'b1, 1'b0, 1'b1, 20'h12, 32'hDEADABEF, 2'd2);

        // 4: round-robin eviction in set 7
        put(4'hF, 20'h1, 10'd7, 32'h11111111, 1'b1, 2'd1, 1'b0);
        get("t4a", 1'b0, 1'b0, 1'b0, '0, '0, '0);
        put(4'hF, 20'h2, 10'd7, 32'h22222222, 1'b1, 2'd1, 1'b0);
        get("t4b", 1'b0, 1'b1, 1'b0, '0, '0, '0);
        put(4'hF, 20'h3, 10'd7, 32'h33333333, 1'b1, 2'd1, 1'b0);
        get("t4c", 1'b0, 1'b0, 1'b1, 20'h1, 32'h11111111, 2'd1);
        put(4'h0, 20'h1, 10'd7, 32'h0, 1'b0, 2'd0, 1'b0);
        get("t4r1", 1'b0, 1'b1, 1'b1, 20'h2, 32'h22222222, 2'd1);
        put(4'h0, 20'h2, 10'd7, 32'h0, 1'b0, 2'd0, 1'b0);
        get("t4r2", 1'b1, 1'b1, 1'b1, 20'h2, 32'h22222222, 2'd1);
        put(4'h0, 20'h3, 10'd7, 32'h0, 1'b0, 2'd0, 1'b0);
        get("t4r3", 1'b1, 1'b0, 1'b1, 20'h3, 32'h33333333, 2'd1);

        // 5: ignore_response write, back-to-back read
        put(4'hF, 20'h40, 10'd9, 32'hCAFEF00D, 1'b1, 2'd2, 1'b1);
        #3;
        chk("t5.get_ready", get_ready, 1'b0);
        chk("t5.put_ready", put_ready, 1'b1);
        put(4'h0, 20'h40, 10'd9, 32'h0, 1'b0, 2'd0, 1'b0);
        get("t5r", 1'b1, 1'b0, 1'b1, 20'h40, 32'hCAFEF00D, 2'd2);

        // invalidate on hit: line then misses, victim unmoved
        put(4'h0, 20'h2, 10'd7, 32'h0, 1'b1, 2'd0, 1'b0);
        get("tinv", 1'b1, 1'b1, 1'b1, 20'h2, 32'h22222222, 2'd1);
        put(4'h0, 20'h2, 10'd7, 32'h0, 1'b0, 2'd0, 1'b0);
        get("tinvr", 1'b0, 1'b1, 1'b1, 20'h2, 32'h22222222, 2'd0);
`ifdef CACHE_STATS_EN
        @(negedge CLK);
        chk("stats.hits", stat_hits, 32'd7);
        chk("stats.misses", stat_misses, 32'd8);
`endif

        // 6: reset with a pending write
        put(4'hF, 20'h55, 10'd3, 32'h12345678, 1'b1, 2'd2, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("t6.get_ready", get_ready, 1'b0);
`ifdef CACHE_STATS_EN
        chk("t6.hits", stat_hits, 32'd0);
        chk("t6.misses", stat_misses, 32'd0);
`endif
        RST = 1'b0;
        put(4'h0, 20'h55, 10'd3, 32'h0, 1'b0, 2'd0, 1'b0);
        get("t6r", 1'b0, 1'b0, 1'b0, '0, '0, '0);
        put(4'h0, 20'h12, 10'd5, 32'h0, 1'b0, 2'd0, 1'b0);
        get("t6r5", 1'b0, 1'b0, 1'b0, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
